// File: rtl/traffic_light_module.sv
// Three-aspect traffic light controller: RED -> GREEN -> YELLOW -> RED.
// Each phase lasts a parameterised number of enabled clock cycles, and the lamps are one-hot registered outputs.
module traffic_light_module #(
  parameter int RED_CYCLES    = 12,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic red,
  output logic yellow,
  output logic green
);

  localparam int MAX_RG = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
  localparam int MAX_C  = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RED_LAST    = CW'(RED_CYCLES - 1);
  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_CYCLES - 1);

  // Lamp vector bit order is {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_BAD    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    lamp;

  // Lamps are written alongside each state change, so they always reflect the
  // state the FSM has just entered, with no decode logic after the flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RED;
      cnt   <= '0;
      lamp  <= LAMP_RED;
    end else if (state == S_BAD) begin
      // The unused encoding recovers regardless of enable.
      state <= S_RED;
      cnt   <= '0;
      lamp  <= LAMP_RED;
    end else if (enable) begin
      case (state)
        S_RED: begin
          if (cnt == RED_LAST) begin
            state <= S_GREEN;
            cnt   <= '0;
            lamp  <= LAMP_GREEN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GREEN: begin
          if (cnt == GREEN_LAST) begin
            state <= S_YELLOW;
            cnt   <= '0;
            lamp  <= LAMP_YELLOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_YELLOW: begin
          if (cnt == YELLOW_LAST) begin
            state <= S_RED;
            cnt   <= '0;
            lamp  <= LAMP_RED;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_RED;
          cnt   <= '0;
          lamp  <= LAMP_RED;
        end
      endcase
    end
  end

  assign red    = lamp[2];
  assign yellow = lamp[1];
  assign green  = lamp[0];

endmodule

// File: tb/tb_traffic_light_module.sv
// Directed bench for traffic_light_module, covering a default-timing instance and an instance with all phases set to 1.
// The expected lamps come from the enabled-edge count N since reset: phase N mod 24 (default) and N mod 3 (all ones).
module tb_traffic_light_module;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic red0, yellow0, green0;
  logic red1, yellow1, green1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n      = 0;
  logic [2:0] prev1;

  always #5 clk = ~clk;

  traffic_light_module u_dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .red(red0), .yellow(yellow0), .green(green0)
  );

  traffic_light_module #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .red(red1), .yellow(yellow1), .green(green1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (N=%0d, t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  // The lamp vector is ordered {red, yellow, green}.
  function automatic logic [2:0] exp_def(input int k);
    int m;
    m = k % 24;
    if (m < 12)      return 3'b100;
    else if (m < 20) return 3'b001;
    else             return 3'b010;
  endfunction

  function automatic logic [2:0] exp_one(input int k);
    case (k % 3)
      0:       return 3'b100;
      1:       return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  // Drive one edge, then sample 1 time unit later and check both instances.
  task automatic step(input logic rst, input logic en);
    logic [2:0] l0, l1;
    reset  = rst;
    enable = en;
    prev1  = {red1, yellow1, green1};
    @(posedge clk);
    #1;
    if (rst) n = 0;
    else if (en) n++;
    l0 = {red0, yellow0, green0};
    l1 = {red1, yellow1, green1};
    chk("onehot0", 8'(red0 + yellow0 + green0), 8'd1);
    chk("onehot1", 8'(red1 + yellow1 + green1), 8'd1);
    chk("model0", 8'(l0), 8'(exp_def(n)));
    chk("model1", 8'(l1), 8'(exp_one(n)));
    if (!rst && en) chk("d1_change", 8'(l1 != prev1), 8'd1);
    if (!rst && !en) chk("d1_hold", 8'(l1), 8'(prev1));
  endtask

  task automatic run(input logic en, input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, en);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    prev1  = 3'b000;
    @(posedge clk);
    #1;
    chk("rst_lamp0", 8'({red0, yellow0, green0}), 8'h4);
    chk("rst_lamp1", 8'({red1, yellow1, green1}), 8'h4);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_held", 8'({red0, yellow0, green0}), 8'h4);

    run(1'b1, 9);
    chk("n9_red", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b0, 10);
    chk("n9_frozen_red", 8'({red0, yellow0, green0}), 8'h4);

    run(1'b1, 2);
    chk("n11_red", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b1, 1);
    chk("n12_green", 8'({red0, yellow0, green0}), 8'h1);
    run(1'b1, 7);
    chk("n19_green", 8'({red0, yellow0, green0}), 8'h1);
    run(1'b0, 5);
    chk("n19_frozen_green", 8'({red0, yellow0, green0}), 8'h1);

    run(1'b1, 1);
    chk("n20_yellow", 8'({red0, yellow0, green0}), 8'h2);
    run(1'b1, 3);
    chk("n23_yellow", 8'({red0, yellow0, green0}), 8'h2);
    run(1'b1, 1);
    chk("n24_wrap_red", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b1, 5);
    chk("n29_red", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b1, 6);
    chk("n35_red", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b1, 1);
    chk("n36_green", 8'({red0, yellow0, green0}), 8'h1);

    // A reset during GREEN discards the partial phase time.
    step(1'b1, 1'b1);
    chk("rst_in_green", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b1, 11);
    chk("post_rst_n11_red", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b1, 1);
    chk("post_rst_n12_green", 8'({red0, yellow0, green0}), 8'h1);

    // Interleave enable to show that only sampled-high edges count.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    chk("n20_yellow_gapped", 8'({red0, yellow0, green0}), 8'h2);
    run(1'b1, 2);
    step(1'b1, 1'b1);
    chk("rst_in_yellow", 8'({red0, yellow0, green0}), 8'h4);
    run(1'b1, 12);
    chk("post_rst2_green", 8'({red0, yellow0, green0}), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

endmodule
